// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-based operand forwarding, load-use stall
// and multi-cycle redirect flush control between ID and EX.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_valid             ID holds a valid instruction
//   id_rs1, id_rs2       ID source registers
//   id_use1, id_use2     ID instruction reads rs1 / rs2
//   id_rd, id_wen        ID destination register and its write enable
//   id_is_load           ID instruction is a load
//   ex_redirect          taken branch / jump resolved in EX this cycle
//   fwd1_sel, fwd2_sel   0 = register file, k = scoreboard stage k (1 = EX)
//   stall                hold PC/ID, bubble into EX
//   flush                squash ID, PC takes redirect target
//   issue                ID instruction enters EX this cycle
//   stall_cnt            saturating stall-cycle counter

module hazard_forward_unit #(
    parameter int DEPTH     = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 2,
    parameter int SW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic [4:0]    id_rd,
    input  logic          id_wen,
    input  logic          id_is_load,
    input  logic          ex_redirect,
    output logic [SW-1:0] fwd1_sel,
    output logic [SW-1:0] fwd2_sel,
    output logic          stall,
    output logic          flush,
    output logic          issue,
    output logic [15:0]   stall_cnt
);

    // Counter only ever holds FLUSH_CYC-1 at most.
    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYC - 1);

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   stall_q;

    // Scoreboard, index 1 = EX stage.
    logic       sb_v   [1:DEPTH];
    logic [4:0] sb_rd  [1:DEPTH];
    logic       sb_wen [1:DEPTH];
    logic       sb_ld  [1:DEPTH];

    logic [SW-1:0] sel1_c;
    logic [SW-1:0] sel2_c;
    logic          haz1;
    logic          haz2;
    logic          m1;
    logic          m2;
    logic          fw;
    logic          flush_c;
    logic          stall_c;
    logic          issue_c;

    // Walk from oldest to youngest so the lowest-k match is the one left.
    always_comb begin
        sel1_c = '0;
        sel2_c = '0;
        haz1   = 1'b0;
        haz2   = 1'b0;
        m1     = 1'b0;
        m2     = 1'b0;
        fw     = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            m1 = id_use1 && sb_v[k] && sb_wen[k] &&
                 (sb_rd[k] == id_rs1) && (id_rs1 != 5'd0);
            m2 = id_use2 && sb_v[k] && sb_wen[k] &&
                 (sb_rd[k] == id_rs2) && (id_rs2 != 5'd0);
            fw = !sb_ld[k] || (k > LOAD_LAT);
            if (m1) begin
                sel1_c = fw ? SW'(k) : '0;
                haz1   = !fw;
            end
            if (m2) begin
                sel2_c = fw ? SW'(k) : '0;
                haz2   = !fw;
            end
        end
    end

    // Redirect outranks a load-use stall.
    assign flush_c = ex_redirect || (state == S_FLUSH);
    assign stall_c = id_valid && (haz1 || haz2) && !flush_c;
    assign issue_c = id_valid && !stall_c && !flush_c;

    assign fwd1_sel  = reset ? '0 : sel1_c;
    assign fwd2_sel  = reset ? '0 : sel2_c;
    assign stall     = !reset && stall_c;
    assign flush     = !reset && flush_c;
    assign issue     = !reset && issue_c;
    assign stall_cnt = reset ? 16'd0 : stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb_v[k]   <= 1'b0;
                sb_rd[k]  <= 5'd0;
                sb_wen[k] <= 1'b0;
                sb_ld[k]  <= 1'b0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_v[k]   <= sb_v[k-1];
                sb_rd[k]  <= sb_rd[k-1];
                sb_wen[k] <= sb_wen[k-1];
                sb_ld[k]  <= sb_ld[k-1];
            end
            sb_v[1]   <= issue_c;
            sb_rd[1]  <= id_rd;
            sb_wen[1] <= id_wen;
            sb_ld[1]  <= id_is_load;
        end
    end

    // cnt counts the FLUSH-state cycles still to come, this one included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (ex_redirect && (FLUSH_CYC > 1)) begin
                        state <= S_FLUSH;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (ex_redirect) begin
                        cnt <= CNT_LOAD;
                    end else begin
                        cnt   <= cnt - CW'(1);
                        state <= (cnt == CW'(1)) ? S_RUN : S_FLUSH;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (stall_c && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard, forwarding and flush controller for the pipelined RV32 core, placed between decode (ID) and execute (EX). It tracks in-flight register writes in a DEPTH-entry scoreboard and produces per-operand forward selects. It also raises load-use stalls with configurable load latency and sequences multi-cycle flushes after a taken branch or jump. Unlike the earlier single-cycle combinational select logic, it has registered pipeline state, a flush FSM and a stall performance counter.

## Interface
- DEPTH, 3: scoreboard entries (stages after ID that can supply a forwarded result), 1..7.
- LOAD_LAT, 1: a load result is forwardable only from stage index > LOAD_LAT.
- FLUSH_CYC, 2: bubble cycles inserted per redirect, ≥1.
- SW, $clog2(DEPTH+1): forward-select width.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  5  ID source register addresses.
- id_use1, id_use2  in  1  ID instruction actually reads rs1 / rs2.
- id_rd  in  5  ID destination register.
- id_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a LOAD.
- ex_redirect  in  1  taken branch / JAL / JALR resolved in EX this cycle.
- fwd1_sel, fwd2_sel  out  SW  0 = register file; k = result of scoreboard stage k (1 = EX).
- stall  out  1  hold PC and ID; insert bubble into EX.
- flush  out  1  squash the instruction in ID; PC takes the redirect target.
- issue  out  1  ID instruction enters EX this cycle.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Scoreboard entry k (1..DEPTH) holds {v, rd, wen, ld}. Each cycle entry k+1 ← entry k, and entry DEPTH drops out. Entry 1 ← {1, id_rd, id_wen, id_is_load} when issue=1, otherwise a bubble (v=0).
- Match for source s at stage k: use_s && entry k v && wen && rd == rs_s && rs_s != 0.
- Forwardable at stage k: !ld || k > LOAD_LAT.
- Only the youngest match (lowest k) counts. If it is forwardable, fwd_sel = k. If not, raise stall and set fwd_sel = 0. With no match, fwd_sel = 0. x0 never matches.
- stall = id_valid && (rs1 hazard || rs2 hazard) && !flush.
- issue = id_valid && !stall && !flush.
- FSM has two states.
  - RUN: ex_redirect → FLUSH, with cnt ← FLUSH_CYC-1. If FLUSH_CYC=1, stay in RUN.
  - FLUSH: cnt decrements each cycle, and at cnt==0 → RUN. An ex_redirect while in FLUSH reloads cnt ← FLUSH_CYC-1.
- flush = ex_redirect || state==FLUSH.
- Redirect and stall in the same cycle: redirect wins. stall=0, and the ID instruction is squashed.
- stall_cnt increments in every cycle with stall=1 and saturates at 0xFFFF.

## Timing
- fwd1_sel, fwd2_sel, stall, flush and issue are combinational from the ID inputs, registered scoreboard state, FSM state and ex_redirect. Zero-cycle latency.
- Scoreboard, FSM, cnt and stall_cnt are registered with 1-cycle update.
- Redirect at cycle T: flush=1 for cycles T..T+FLUSH_CYC-1, issue=0 throughout, and the scoreboard receives bubbles.
- Load-use stall: at most LOAD_LAT+1-k cycles for a match at stage k. It releases without any external handshake.
- Reset behaviour:
  - While reset=1, all outputs are forced to 0: fwd=0, stall=0, flush=0, issue=0, stall_cnt=0.
  - On the first edge with reset high, all entries are cleared to v=0, the FSM goes to RUN, cnt=0 and stall_cnt=0.
  - Reset during FLUSH or during a stall abandons the operation immediately, with no residual flush or stall afterwards.

## Test plan
- Back-to-back ALU hazard, defaults: issue `add x5`, next cycle ID reads rs1=x5 → fwd1_sel=1, stall=0, issue=1. One more cycle with an unrelated ID instruction, then ID reads x5 → fwd1_sel=2.
- Load-use, LOAD_LAT=1: issue `lw x7`, next cycle ID reads rs2=x7 → stall=1 for exactly 1 cycle. The following cycle gives fwd2_sel=2, issue=1, and stall_cnt=1.
- Youngest wins: x3 is written by stage-2 and stage-1 instructions, ID reads x3 on both operands → fwd1_sel=fwd2_sel=1.
- x0: an in-flight write of x0 followed by an ID read of x0 with id_use1=1 → fwd1_sel=0, stall=0. A load to x0 causes no stall.
- Redirect, FLUSH_CYC=2: ex_redirect at T → flush=1 at T and T+1, issue=0, flush=0 at T+2. A second redirect at T+1 extends flush through T+2. A redirect coinciding with a load-use hazard gives stall=0, flush=1.
- Reset/saturation: assert reset mid-FLUSH → next cycle flush=0, scoreboard empty, fwd_sel=0. Force 70000 stall cycles → stall_cnt holds at 0xFFFF.
